multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Parameter: CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Port: clock  input  1  master clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clock.
REQ-005 Port: data_operandA  input  WIDTH  signed two's-complement multiplicand / dividend.
REQ-006 Port: data_operandB  input  WIDTH  signed two's-complement multiplier / divisor.
REQ-007 Port: ctrl_MULT  input  1  one-cycle start pulse for multiply.
REQ-008 Port: ctrl_DIV  input  1  one-cycle start pulse for divide.
REQ-009 Port: data_result  output  WIDTH  signed result.
REQ-010 Port: data_exception  output  1  overflow / divide-by-zero flag, valid with result.
REQ-011 Port: data_resultRDY  output  1  single-cycle completion strobe.
REQ-012 Port: busy  output  1  high while an operation is in flight; pipeline stall source.

Function
REQ-013 FSM states: IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-014 Start: ctrl_MULT or ctrl_DIV high at a rising edge SHALL latch both operands and enter MUL or DIV, iteration counter = 0.
REQ-015 Start priority: ctrl_MULT and ctrl_DIV both high at the same edge -> multiply; ctrl_DIV ignored.
REQ-016 Operands SHALL be sampled only at the start edge; later operand changes SHALL NOT affect the result.
REQ-017 Multiply: iterative shift-add (radix-2 or Booth), one step per cycle, exactly WIDTH iteration cycles.
REQ-018 Divide: iterative restoring or non-restoring on magnitudes, one quotient bit per cycle, exactly WIDTH iteration cycles; sign fixed up in the final step.
REQ-019 Latency: data_resultRDY SHALL go high in the cycle after the WIDTH-th rising edge following the start edge, for exactly one cycle (state DONE), then return to IDLE.
REQ-020 Latency SHALL be fixed and data-independent, including zero operands, divide-by-zero and overflow cases.
REQ-021 busy SHALL be high from the cycle after the start edge through the last iteration cycle; low in IDLE and DONE.
REQ-022 Multiply result: low WIDTH bits of the full 2*WIDTH signed product.
REQ-023 Multiply exception: 1 iff the full signed product is not representable in WIDTH bits (upper WIDTH+1 bits not all equal).
REQ-024 Divide result: quotient truncated toward zero; remainder discarded.
REQ-025 Divide by zero: result 0, exception 1.
REQ-026 Divide of most-negative value by -1: result = most-negative value (0x80000000 at WIDTH 32), exception 1.
REQ-027 data_result and data_exception SHALL update only at the DONE transition and hold until the next completion; RDY-low values SHALL NOT glitch.
REQ-028 Restart: a start pulse during MUL, DIV or DONE SHALL abandon the current operation without asserting RDY and begin the new one per REQ-014; latency counts from the new start edge.
REQ-029 Start pulses lasting more than one cycle: each high edge is a restart; the result corresponds to the last start edge.

Reset
REQ-030 reset low: state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0, all internal datapath registers 0.
REQ-031 Reset asserted mid-operation SHALL abort it; no RDY pulse for the aborted operation after reset release.
REQ-032 First start pulse SHALL be honoured on the first rising edge after reset deasserts.

Verification (WIDTH=32)
REQ-033 ctrl_MULT pulse, A=7, B=-3 -> RDY exactly one cycle, after edge 32 post-start; result 0xFFFFFFEB (-21), exception 0; busy high for cycles 1..32.
REQ-034 ctrl_MULT, A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception 0.
REQ-035 ctrl_DIV, A=-7, B=2 -> result 0xFFFFFFFD (-3), exception 0; A=5, B=0 -> result 0, exception 1, same latency.
REQ-036 ctrl_DIV, A=0x80000000, B=-1 -> result 0x80000000, exception 1; ctrl_MULT and ctrl_DIV together with A=6, B=3 -> result 18 (multiply).
REQ-037 ctrl_MULT (A=3, B=4), then ctrl_DIV (A=100, B=7) 10 cycles later -> no RDY for the multiply; single RDY 32 edges after the divide start with result 14.
REQ-038 Reset driven low at cycle 15 of a multiply, released at 20 -> outputs 0 immediately on assertion, no RDY thereafter; new ctrl_MULT (A=2, B=2) -> result 4 at normal latency.

Source files
------------

// File: rtl/multdiv_unit_if.sv
// Bus between a pipeline and the iterative multiply/divide unit.
// Handshake: ctrl_MULT / ctrl_DIV are start strobes sampled on every rising
// clock edge, together with data_operandA/B. The unit never back-pressures a
// start. A start while busy abandons the operation in flight. data_resultRDY
// is a one-cycle strobe. data_result / data_exception are valid while it is
// high and hold until the next completion.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / divide unit with fixed WIDTH-cycle latency.
// Multiply is radix-2 shift-add over a 2*WIDTH accumulator. The multiplier's
// sign bit is weighted negatively, so the final step subtracts.
// Divide is restoring division on magnitudes. The quotient shifts into the
// dividend register. Sign, overflow and divide-by-zero are fixed up on the
// last step.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clock,
    input  logic        reset,
    multdiv_unit_if.slave bus,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;       // product accumulator
    logic [2*WIDTH-1:0] sh_a;      // shifted multiplicand / divisor magnitude
    logic [WIDTH-1:0]   sh_b;      // multiplier bits / dividend-then-quotient
    logic [WIDTH:0]     rem;       // partial remainder (one guard bit)
    logic               neg;       // quotient must be negated
    logic               div_zero;  // divisor was zero at start

    logic               last;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               mul_ovf;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH:0]     rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   div_res;
    logic               div_ovf;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               start;

    assign state_dbg = state;
    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign last      = (cnt == CNT_W'(WIDTH - 1));

    // One iteration step of each datapath, evaluated from the current registers.
    always_comb begin
        addend  = sh_b[0] ? sh_a : '0;
        acc_nxt = last ? (acc - addend) : (acc + addend);
        // Representable only if the upper WIDTH+1 product bits are all equal.
        mul_ovf = !((&acc_nxt[2*WIDTH-1:WIDTH-1]) || !(|acc_nxt[2*WIDTH-1:WIDTH-1]));

        rem_sh  = {rem[WIDTH-1:0], sh_b[WIDTH-1]};
        diff    = rem_sh - {1'b0, sh_a[WIDTH-1:0]};
        q_bit   = !diff[WIDTH];
        rem_nxt = q_bit ? diff : rem_sh;
        quo_nxt = {sh_b[WIDTH-2:0], q_bit};
        // A positive quotient with its MSB set only arises from MIN / -1.
        div_ovf = !neg && quo_nxt[WIDTH-1];
        div_res = neg ? (WIDTH'(0) - quo_nxt) : quo_nxt;

        mag_a   = bus.data_operandA[WIDTH-1] ? (WIDTH'(0) - bus.data_operandA) : bus.data_operandA;
        mag_b   = bus.data_operandB[WIDTH-1] ? (WIDTH'(0) - bus.data_operandB) : bus.data_operandB;
    end

    // Control FSM and datapath registers. A start wins in every state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            cnt                <= '0;
            acc                <= '0;
            sh_a               <= '0;
            sh_b               <= '0;
            rem                <= '0;
            neg                <= 1'b0;
            div_zero           <= 1'b0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else if (start) begin
            cnt                <= '0;
            acc                <= '0;
            rem                <= '0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b1;
            if (bus.ctrl_MULT) begin
                state    <= MUL;
                sh_a     <= {{WIDTH{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                sh_b     <= bus.data_operandB;
                neg      <= 1'b0;
                div_zero <= 1'b0;
            end else begin
                state    <= DIV;
                sh_a     <= {{WIDTH{1'b0}}, mag_b};
                sh_b     <= mag_a;
                neg      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                div_zero <= (bus.data_operandB == '0);
            end
        end else begin
            case (state)
                MUL: begin
                    acc  <= acc_nxt;
                    sh_a <= {sh_a[2*WIDTH-2:0], 1'b0};
                    sh_b <= {1'b0, sh_b[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state              <= DONE;
                        bus.data_result    <= acc_nxt[WIDTH-1:0];
                        bus.data_exception <= mul_ovf;
                        bus.data_resultRDY <= 1'b1;
                        bus.busy           <= 1'b0;
                    end
                end
                DIV: begin
                    rem  <= rem_nxt;
                    sh_b <= quo_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state              <= DONE;
                        bus.data_result    <= div_zero ? '0 : div_res;
                        bus.data_exception <= div_zero | div_ovf;
                        bus.data_resultRDY <= 1'b1;
                        bus.busy           <= 1'b0;
                    end
                end
                default: begin
                    state              <= IDLE;
                    bus.data_resultRDY <= 1'b0;
                    bus.busy           <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit at WIDTH=32 with hand-computed expectations.
module tb_multdiv_unit;
    logic        clock;
    logic        reset;
    logic [1:0]  state_dbg;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    multdiv_unit_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a one-cycle start, then scramble the operands.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Watch 40 cycles after a start edge and score the completion.
    task automatic watch(input string tag, input logic exp_exc);
        int          first_rdy = -1;
        int          n_rdy     = 0;
        int          n_busy    = 0;
        logic [31:0] res_at    = '0;
        logic        exc_at    = 1'b0;
        logic [31:0] exp_res;
        exp_res = exp_q.pop_front();
        check({tag, "_busy_start"}, 64'(bus.busy), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (bus.data_resultRDY) begin
                n_rdy++;
                if (first_rdy < 0) begin
                    first_rdy = k;
                    res_at    = bus.data_result;
                    exc_at    = bus.data_exception;
                end
            end
            if (bus.busy) n_busy++;
        end
        check({tag, "_latency"}, 64'(first_rdy), 64'd32);
        check({tag, "_rdy_count"}, 64'(n_rdy), 64'd1);
        check({tag, "_busy_cycles"}, 64'(n_busy), 64'd31);
        check({tag, "_result"}, 64'(res_at), 64'(exp_res));
        check({tag, "_exception"}, 64'(exc_at), 64'(exp_exc));
        check({tag, "_hold"}, 64'(bus.data_result), 64'(exp_res));
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        exp_q.push_back(exp_res);
        start_op(m, d, a, b);
        watch(tag, exp_exc);
    endtask

    initial begin
        int n_rdy;
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        #3 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_result", 64'(bus.data_result), 64'd0);
        check("rst_exc", 64'(bus.data_exception), 64'd0);
        check("rst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        reset = 1'b1;

        run_op("mul_7_m3",     1, 0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mul_ovf",      1, 0, 32'h00010000,   32'h00010000, 32'h00000000, 1'b1);
        run_op("mul_max_1",    1, 0, 32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 1'b0);
        run_op("mul_min_m1",   1, 0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("mul_m1_m1",    1, 0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        1'b0);
        run_op("mul_zero",     1, 0, 32'd0,          32'h12345678, 32'd0,        1'b0);
        run_op("div_m7_2",     0, 1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("div_by_zero",  0, 1, 32'd5,          32'd0,        32'd0,        1'b1);
        run_op("div_min_m1",   0, 1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_op("div_100_m7",   0, 1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
        run_op("div_m100_m7",  0, 1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       1'b0);
        run_op("div_3_7",      0, 1, 32'd3,          32'd7,        32'd0,        1'b0);
        run_op("both_6_3",     1, 1, 32'd6,          32'd3,        32'd18,       1'b0);

        // Restart: a divide ten cycles into a multiply abandons the multiply.
        n_rdy = 0;
        start_op(1, 0, 32'd3, 32'd4);
        repeat (8) begin
            @(negedge clock);
            if (bus.data_resultRDY) n_rdy++;
        end
        check("restart_no_rdy", 64'(n_rdy), 64'd0);
        exp_q.push_back(32'd14);
        start_op(0, 1, 32'd100, 32'd7);
        watch("restart_div", 1'b0);

        // Reset in the middle of a multiply.
        n_rdy = 0;
        start_op(1, 0, 32'd5, 32'd5);
        repeat (14) begin
            @(negedge clock);
            if (bus.data_resultRDY) n_rdy++;
        end
        #2 reset = 1'b0;
        #1;
        check("midrst_result", 64'(bus.data_result), 64'd0);
        check("midrst_exc", 64'(bus.data_exception), 64'd0);
        check("midrst_rdy", 64'(bus.data_resultRDY), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_state", 64'(state_dbg), 64'd0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (bus.data_resultRDY) n_rdy++;
        end
        check("midrst_no_rdy", 64'(n_rdy), 64'd0);
        run_op("post_rst_mul", 1, 0, 32'd2, 32'd2, 32'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
